multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle successor to the single-cycle main decoder: a Moore/Mealy FSM that walks each
//  instruction through FETCH/DECODE/EXEC/MEM/WB, emitting the datapath control word per state.
//  Sits between the instruction register (opcode) and the shared-memory datapath. Adds memory
//  ready handshake, wait timeout with sticky fault, and illegal-opcode flagging for wider opcodes.
// PARAMETERS
//  OP_WIDTH    2   opcode width; legal opcodes are 0..3 (upper bits zero), others are illegal
//  WAIT_LIMIT  15  max stalled cycles on input_MemReady before FAULT; 0 disables the timeout
// PORTS
//  input_Clk         in   1   clock, rising edge
//  input_Reset_n     in   1   reset, asynchronous, active-low
//  input_Operator    in   OP_WIDTH  opcode from IR; valid from DECODE onward
//  input_MemReady    in   1   memory completes access this cycle
//  input_Zero        in   1   ALU zero flag (branch compare)
//  output_RegDst, output_RegWrite, output_ALUSrc, output_Branch,
//  output_MemRead, output_MemWrite, output_MemtoReg   out 1 each  datapath controls
//  output_ALUOp      out  2   00 add, 01 sub (branch), 10 funct (R-type)
//  output_IorD       out  1   0 = PC addresses memory, 1 = ALU result
//  output_IRWrite    out  1   load instruction register
//  output_PCWrite    out  1   load PC (fetch increment or taken branch)
//  output_Illegal    out  1   one-cycle pulse: illegal opcode
//  output_Fault      out  1   sticky memory-timeout fault
//  output_State      out  3   current state encoding, for debug
// BEHAVIOUR
//  - States: RESET_S=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 FAULT=6. Reset -> RESET_S, wait cnt 0,
//    op_q 0; all outputs 0 while in reset and in RESET_S. RESET_S -> FETCH unconditionally.
//  - Opcodes: 00 R-type, 01 LW, 10 SW, 11 BEQ. op_q <= input_Operator on the DECODE cycle;
//    EXEC/MEM/WB decode from op_q only.
//  - FETCH: MemRead=1 IorD=0 ALUOp=00. Stay until MemReady; on the ready cycle IRWrite=1,
//    PCWrite=1 (Mealy), next DECODE. DECODE: all controls 0, next EXEC.
//  - EXEC: R: ALUOp=10 -> WB. LW/SW: ALUSrc=1 ALUOp=00 -> MEM. BEQ: Branch=1 ALUOp=01,
//    PCWrite=input_Zero -> FETCH. Illegal: Illegal=1, no other controls -> FETCH.
//  - MEM: LW: MemRead=1 IorD=1 ALUSrc=1; SW: MemWrite=1 IorD=1 ALUSrc=1. Held until MemReady;
//    LW -> WB, SW -> FETCH on the ready cycle.
//  - WB: R: RegDst=1 RegWrite=1 ALUOp=10; LW: RegWrite=1 MemtoReg=1. -> FETCH.
//  - Latency (zero wait): BEQ 3, R/SW 4, LW 5 cycles; each memory wait cycle adds 1.
//  - Wait counter: width $clog2(WAIT_LIMIT+1); increments each FETCH/MEM cycle with MemReady=0,
//    clears on MemReady or any state change. If cnt==WAIT_LIMIT and MemReady=0 -> FAULT.
//    MemReady on the limit cycle wins (no fault). WAIT_LIMIT=0: counter inert, never faults.
//  - FAULT: all controls 0, Fault=1, absorbing until reset.
//  - Async reset mid-operation: outputs drop to 0 immediately, no partial write completes.
//  - Controls not listed for a state are 0. No latches: every output has a default.
// STRUCTURE
//  - control_pkg: state encodings, opcode constants, ALUOp codes, control-word bit indices.
//  - Sub-module opcode_decoder: combinational op_q -> {is_r, is_lw, is_sw, is_beq, illegal}.
//  - Top: state register, wait counter, op_q register, per-state output case.
// TESTING
//  1 Reset_n=0 -> all outputs 0, State=0; release -> 1 cycle RESET_S, then FETCH MemRead=1.
//  2 op=00, MemReady=1 -> State 1,2,3,5,1; WB: RegDst=1 RegWrite=1 ALUOp=10; IRWrite/PCWrite in FETCH.
//  3 op=01, MemReady low 3 cycles in MEM -> MEM held 4 cycles MemRead=1 IorD=1; WB MemtoReg=1.
//  4 op=11 Zero=1 -> EXEC Branch=1 ALUOp=01 PCWrite=1; Zero=0 -> PCWrite=0; back to FETCH.
//  5 WAIT_LIMIT=4, MemReady=0 -> FAULT after 5 FETCH cycles, Fault sticky; ready on 5th -> no fault.
//  6 OP_WIDTH=3 op=101 -> Illegal pulse in EXEC, FETCH next; Reset_n=0 mid-MEM -> outputs 0 at once.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and constants for the multi-cycle control unit: state encodings,
// opcode values, ALUOp codes, control-word bit positions and the opcode class bundle.
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        RESET_S = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        FAULT   = 3'd6
    } state_e;

    localparam logic [1:0] OP_R   = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control-word bit positions (ALUOp occupies two bits starting at CW_ALUOP)
    localparam int unsigned CW_REGDST   = 0;
    localparam int unsigned CW_REGWRITE = 1;
    localparam int unsigned CW_ALUSRC   = 2;
    localparam int unsigned CW_BRANCH   = 3;
    localparam int unsigned CW_MEMREAD  = 4;
    localparam int unsigned CW_MEMWRITE = 5;
    localparam int unsigned CW_MEMTOREG = 6;
    localparam int unsigned CW_ALUOP    = 7;
    localparam int unsigned CW_IORD     = 9;
    localparam int unsigned CW_IRWRITE  = 10;
    localparam int unsigned CW_PCWRITE  = 11;
    localparam int unsigned CW_ILLEGAL  = 12;
    localparam int unsigned CW_FAULT    = 13;
    localparam int unsigned CW_WIDTH    = 14;

    typedef struct packed {
        logic is_r;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Handshake/control bundle between the control unit (master) and the datapath (slave).
// Inputs to the control unit: opcode, memory ready, ALU zero.
// Outputs from the control unit: datapath control lines, illegal pulse, fault, debug state.
interface multicycle_control_unit_if #(
    parameter int unsigned OP_WIDTH = 2
);
    logic [OP_WIDTH-1:0] input_Operator;
    logic                input_MemReady;
    logic                input_Zero;

    logic       output_RegDst;
    logic       output_RegWrite;
    logic       output_ALUSrc;
    logic       output_Branch;
    logic       output_MemRead;
    logic       output_MemWrite;
    logic       output_MemtoReg;
    logic [1:0] output_ALUOp;
    logic       output_IorD;
    logic       output_IRWrite;
    logic       output_PCWrite;
    logic       output_Illegal;
    logic       output_Fault;
    logic [2:0] output_State;

    modport master (
        input  input_Operator, input_MemReady, input_Zero,
        output output_RegDst, output_RegWrite, output_ALUSrc, output_Branch,
               output_MemRead, output_MemWrite, output_MemtoReg, output_ALUOp,
               output_IorD, output_IRWrite, output_PCWrite, output_Illegal,
               output_Fault, output_State
    );

    modport slave (
        output input_Operator, input_MemReady, input_Zero,
        input  output_RegDst, output_RegWrite, output_ALUSrc, output_Branch,
               output_MemRead, output_MemWrite, output_MemtoReg, output_ALUOp,
               output_IorD, output_IRWrite, output_PCWrite, output_Illegal,
               output_Fault, output_State
    );
endinterface

// File: rtl/multicycle_control_unit_opcode_decoder.sv
// Combinational opcode classifier.
// op_q       : latched opcode
// op_class_c : one-hot class {is_r, is_lw, is_sw, is_beq, illegal}
module multicycle_control_unit_opcode_decoder
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned OP_WIDTH = 2
) (
    input  logic [OP_WIDTH-1:0] op_q,
    output op_class_t           op_class_c
);

    // Any set bit above the 2-bit legal range makes the opcode illegal
    always_comb begin
        op_class_c = '0;
        if ((op_q >> 2) != '0) begin
            op_class_c.illegal = 1'b1;
        end else begin
            case (op_q[1:0])
                OP_R:    op_class_c.is_r   = 1'b1;
                OP_LW:   op_class_c.is_lw  = 1'b1;
                OP_SW:   op_class_c.is_sw  = 1'b1;
                default: op_class_c.is_beq = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with memory-ready stalls,
// wait timeout into a sticky FAULT state, and illegal-opcode flagging.
// input_Clk     : clock, rising edge
// input_Reset_n : asynchronous active-low reset
// bus           : master side of multicycle_control_unit_if (opcode/ready/zero in,
//                 datapath controls, Illegal, Fault, State out)
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned OP_WIDTH   = 2,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic                      input_Clk,
    input  logic                      input_Reset_n,
    multicycle_control_unit_if.master bus
);

    localparam int unsigned CNT_W = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_WIDTH-1:0] op_q;
    op_class_t           op_class_c;
    logic [CW_WIDTH-1:0] cw_c;
    logic                waiting_c;
    logic                timeout_c;

    multicycle_control_unit_opcode_decoder #(
        .OP_WIDTH (OP_WIDTH)
    ) u_opcode_decoder (
        .op_q       (op_q),
        .op_class_c (op_class_c)
    );

    // State, wait counter and opcode latch
    always_ff @(posedge input_Clk or negedge input_Reset_n) begin
        if (!input_Reset_n) begin
            state_q <= RESET_S;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == DECODE) begin
                op_q <= bus.input_Operator;
            end
        end
    end

    // Stall detection: only FETCH and MEM wait on memory
    always_comb begin
        waiting_c = ((state_q == FETCH) || (state_q == MEM)) && !bus.input_MemReady;
        timeout_c = (WAIT_LIMIT != 0) && waiting_c && (cnt_q == CNT_W'(WAIT_LIMIT));
    end

    // Next state and control word
    always_comb begin
        state_d = state_q;
        cw_c    = '0;
        case (state_q)
            RESET_S: state_d = FETCH;
            FETCH: begin
                cw_c[CW_MEMREAD]       = 1'b1;
                cw_c[CW_ALUOP +: 2]    = ALUOP_ADD;
                if (bus.input_MemReady) begin
                    cw_c[CW_IRWRITE] = 1'b1;
                    cw_c[CW_PCWRITE] = 1'b1;
                    state_d          = DECODE;
                end else if (timeout_c) begin
                    state_d = FAULT;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (op_class_c.illegal) begin
                    cw_c[CW_ILLEGAL] = 1'b1;
                    state_d          = FETCH;
                end else if (op_class_c.is_r) begin
                    cw_c[CW_ALUOP +: 2] = ALUOP_FUNCT;
                    state_d             = WB;
                end else if (op_class_c.is_lw || op_class_c.is_sw) begin
                    cw_c[CW_ALUSRC]     = 1'b1;
                    cw_c[CW_ALUOP +: 2] = ALUOP_ADD;
                    state_d             = MEM;
                end else begin
                    cw_c[CW_BRANCH]     = 1'b1;
                    cw_c[CW_ALUOP +: 2] = ALUOP_SUB;
                    cw_c[CW_PCWRITE]    = bus.input_Zero;
                    state_d             = FETCH;
                end
            end
            MEM: begin
                cw_c[CW_IORD]     = 1'b1;
                cw_c[CW_ALUSRC]   = 1'b1;
                cw_c[CW_MEMREAD]  = op_class_c.is_lw;
                cw_c[CW_MEMWRITE] = op_class_c.is_sw;
                if (bus.input_MemReady) begin
                    state_d = op_class_c.is_lw ? WB : FETCH;
                end else if (timeout_c) begin
                    state_d = FAULT;
                end
            end
            WB: begin
                if (op_class_c.is_r) begin
                    cw_c[CW_REGDST]     = 1'b1;
                    cw_c[CW_REGWRITE]   = 1'b1;
                    cw_c[CW_ALUOP +: 2] = ALUOP_FUNCT;
                end else if (op_class_c.is_lw) begin
                    cw_c[CW_REGWRITE] = 1'b1;
                    cw_c[CW_MEMTOREG] = 1'b1;
                end
                state_d = FETCH;
            end
            FAULT: cw_c[CW_FAULT] = 1'b1;
            default: state_d = RESET_S;
        endcase
    end

    // Counter advances only while stalled in the same state; any ready or transition clears it
    always_comb begin
        cnt_d = '0;
        if ((WAIT_LIMIT != 0) && waiting_c && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign bus.output_RegDst   = cw_c[CW_REGDST];
    assign bus.output_RegWrite = cw_c[CW_REGWRITE];
    assign bus.output_ALUSrc   = cw_c[CW_ALUSRC];
    assign bus.output_Branch   = cw_c[CW_BRANCH];
    assign bus.output_MemRead  = cw_c[CW_MEMREAD];
    assign bus.output_MemWrite = cw_c[CW_MEMWRITE];
    assign bus.output_MemtoReg = cw_c[CW_MEMTOREG];
    assign bus.output_ALUOp    = cw_c[CW_ALUOP +: 2];
    assign bus.output_IorD     = cw_c[CW_IORD];
    assign bus.output_IRWrite  = cw_c[CW_IRWRITE];
    assign bus.output_PCWrite  = cw_c[CW_PCWRITE];
    assign bus.output_Illegal  = cw_c[CW_ILLEGAL];
    assign bus.output_Fault    = cw_c[CW_FAULT];
    assign bus.output_State    = 3'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit (OP_WIDTH=3, WAIT_LIMIT=4).
module tb_multicycle_control_unit;

    // Observed control vector layout:
    // {RegDst,RegWrite,ALUSrc,Branch,MemRead,MemWrite,MemtoReg,ALUOp[1:0],IorD,IRWrite,PCWrite,Illegal,Fault}
    localparam logic [13:0] C_REGDST    = 14'h2000;
    localparam logic [13:0] C_REGWRITE  = 14'h1000;
    localparam logic [13:0] C_ALUSRC    = 14'h0800;
    localparam logic [13:0] C_BRANCH    = 14'h0400;
    localparam logic [13:0] C_MEMREAD   = 14'h0200;
    localparam logic [13:0] C_MEMWRITE  = 14'h0100;
    localparam logic [13:0] C_MEMTOREG  = 14'h0080;
    localparam logic [13:0] C_ALU_FUNCT = 14'h0040;
    localparam logic [13:0] C_ALU_SUB   = 14'h0020;
    localparam logic [13:0] C_IORD      = 14'h0010;
    localparam logic [13:0] C_IRWRITE   = 14'h0008;
    localparam logic [13:0] C_PCWRITE   = 14'h0004;
    localparam logic [13:0] C_ILLEGAL   = 14'h0002;
    localparam logic [13:0] C_FAULT     = 14'h0001;
    localparam logic [13:0] C_FETCH_RDY = C_MEMREAD | C_IRWRITE | C_PCWRITE;

    localparam logic [2:0] S_RESET = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [13:0] ctrl;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.OP_WIDTH(3)) bus ();

    multicycle_control_unit #(
        .OP_WIDTH   (3),
        .WAIT_LIMIT (4)
    ) dut (
        .input_Clk     (clk),
        .input_Reset_n (rst_n),
        .bus           (bus)
    );

    assign ctrl = {bus.output_RegDst, bus.output_RegWrite, bus.output_ALUSrc, bus.output_Branch,
                   bus.output_MemRead, bus.output_MemWrite, bus.output_MemtoReg, bus.output_ALUOp,
                   bus.output_IorD, bus.output_IRWrite, bus.output_PCWrite, bus.output_Illegal,
                   bus.output_Fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] exp_st, input logic [13:0] exp_cw);
        check({tag, ".state"}, 32'(bus.output_State), 32'(exp_st));
        check({tag, ".ctrl"},  32'(ctrl),             32'(exp_cw));
    endtask

    // One clock: drive inputs on the falling edge, then check the current state's outputs
    task automatic cyc(input string tag, input logic [2:0] op, input logic rdy, input logic z,
                       input logic [2:0] exp_st, input logic [13:0] exp_cw);
        @(negedge clk);
        bus.input_Operator = op;
        bus.input_MemReady = rdy;
        bus.input_Zero     = z;
        #1;
        check_outputs(tag, exp_st, exp_cw);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.input_Operator = '0;
        bus.input_MemReady = 1'b0;
        bus.input_Zero     = 1'b0;

        #2 check_outputs("reset", S_RESET, '0);
        @(negedge clk);
        check_outputs("reset_held", S_RESET, '0);
        rst_n = 1'b1;
        #1 check_outputs("rst_s", S_RESET, '0);

        // R-type, zero wait
        cyc("r_fetch", 3'd0, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY);
        cyc("r_dec",   3'd0, 1'b1, 1'b0, S_DECODE, '0);
        cyc("r_exec",  3'd0, 1'b1, 1'b0, S_EXEC,   C_ALU_FUNCT);
        cyc("r_wb",    3'd0, 1'b1, 1'b0, S_WB,     C_REGDST | C_REGWRITE | C_ALU_FUNCT);

        // LW with one fetch wait and three memory waits
        cyc("lw_fwait", 3'd1, 1'b0, 1'b0, S_FETCH,  C_MEMREAD);
        cyc("lw_fetch", 3'd1, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY);
        cyc("lw_dec",   3'd1, 1'b1, 1'b0, S_DECODE, '0);
        cyc("lw_exec",  3'd1, 1'b0, 1'b0, S_EXEC,   C_ALUSRC);
        cyc("lw_mem0",  3'd1, 1'b0, 1'b0, S_MEM,    C_MEMREAD | C_IORD | C_ALUSRC);
        cyc("lw_mem1",  3'd1, 1'b0, 1'b0, S_MEM,    C_MEMREAD | C_IORD | C_ALUSRC);
        cyc("lw_mem2",  3'd1, 1'b0, 1'b0, S_MEM,    C_MEMREAD | C_IORD | C_ALUSRC);
        cyc("lw_mem3",  3'd1, 1'b1, 1'b0, S_MEM,    C_MEMREAD | C_IORD | C_ALUSRC);
        cyc("lw_wb",    3'd1, 1'b1, 1'b0, S_WB,     C_REGWRITE | C_MEMTOREG);

        // SW, zero wait
        cyc("sw_fetch", 3'd2, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY);
        cyc("sw_dec",   3'd2, 1'b1, 1'b0, S_DECODE, '0);
        cyc("sw_exec",  3'd2, 1'b1, 1'b0, S_EXEC,   C_ALUSRC);
        cyc("sw_mem",   3'd2, 1'b1, 1'b0, S_MEM,    C_MEMWRITE | C_IORD | C_ALUSRC);

        // BEQ taken then not taken
        cyc("beq1_fetch", 3'd3, 1'b1, 1'b1, S_FETCH,  C_FETCH_RDY);
        cyc("beq1_dec",   3'd3, 1'b1, 1'b1, S_DECODE, '0);
        cyc("beq1_exec",  3'd3, 1'b1, 1'b1, S_EXEC,   C_BRANCH | C_ALU_SUB | C_PCWRITE);
        cyc("beq0_fetch", 3'd3, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY);
        cyc("beq0_dec",   3'd3, 1'b1, 1'b0, S_DECODE, '0);
        cyc("beq0_exec",  3'd3, 1'b1, 1'b0, S_EXEC,   C_BRANCH | C_ALU_SUB);

        // Illegal opcode 101: pulse in EXEC only, then FETCH
        cyc("ill_fetch", 3'd5, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY);
        cyc("ill_dec",   3'd5, 1'b1, 1'b0, S_DECODE, '0);
        cyc("ill_exec",  3'd5, 1'b1, 1'b0, S_EXEC,   C_ILLEGAL);

        // Fetch stalls four cycles, ready on the fifth (limit cycle): no fault
        cyc("lim_w1",   3'd0, 1'b0, 1'b0, S_FETCH,  C_MEMREAD);
        cyc("lim_w2",   3'd0, 1'b0, 1'b0, S_FETCH,  C_MEMREAD);
        cyc("lim_w3",   3'd0, 1'b0, 1'b0, S_FETCH,  C_MEMREAD);
        cyc("lim_w4",   3'd0, 1'b0, 1'b0, S_FETCH,  C_MEMREAD);
        cyc("lim_rdy",  3'd0, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY);
        cyc("lim_dec",  3'd0, 1'b1, 1'b0, S_DECODE, '0);
        cyc("lim_exec", 3'd0, 1'b1, 1'b0, S_EXEC,   C_ALU_FUNCT);
        cyc("lim_wb",   3'd0, 1'b1, 1'b0, S_WB,     C_REGDST | C_REGWRITE | C_ALU_FUNCT);

        // Asynchronous reset in the middle of an LW memory stall
        cyc("ar_fetch", 3'd1, 1'b1, 1'b0, S_FETCH,  C_FETCH_RDY);
        cyc("ar_dec",   3'd1, 1'b1, 1'b0, S_DECODE, '0);
        cyc("ar_exec",  3'd1, 1'b0, 1'b0, S_EXEC,   C_ALUSRC);
        cyc("ar_mem",   3'd1, 1'b0, 1'b0, S_MEM,    C_MEMREAD | C_IORD | C_ALUSRC);
        #1 rst_n = 1'b0;
        #1 check_outputs("ar_async", S_RESET, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_outputs("ar_rst_s", S_RESET, '0);

        // Five stalled fetch cycles reach the limit: FAULT, sticky even with ready
        cyc("to_w1", 3'd0, 1'b0, 1'b0, S_FETCH, C_MEMREAD);
        cyc("to_w2", 3'd0, 1'b0, 1'b0, S_FETCH, C_MEMREAD);
        cyc("to_w3", 3'd0, 1'b0, 1'b0, S_FETCH, C_MEMREAD);
        cyc("to_w4", 3'd0, 1'b0, 1'b0, S_FETCH, C_MEMREAD);
        cyc("to_w5", 3'd0, 1'b0, 1'b0, S_FETCH, C_MEMREAD);
        cyc("fault0", 3'd0, 1'b1, 1'b1, S_FAULT, C_FAULT);
        cyc("fault1", 3'd0, 1'b1, 1'b1, S_FAULT, C_FAULT);
        cyc("fault2", 3'd3, 1'b0, 1'b0, S_FAULT, C_FAULT);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
